// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator for a VGA-style display. It produces horizontal and
// vertical sync, active-area flags and the current pixel coordinate. The
// horizontal and vertical positions each move through four segments:
// ACTIVE -> FRONT porch -> SYNC -> BACK porch.
//
// Ports
//   pixel_clk   in   sole clock; all logic runs on its rising edge
//   rst         in   synchronous, active-low reset
//   pix_en      in   pixel advance strobe; nothing moves while it is low
//   VGA_HS      out  horizontal sync, SYNC_POL level inside the sync segment
//   VGA_VS      out  vertical sync, SYNC_POL level inside the sync segment
//   Hact        out  high while pixel_x < H_ACTIVE
//   Vact        out  high while pixel_y < V_ACTIVE
//   data_en     out  Hact & Vact
//   pixel_x     out  horizontal position, 0 .. H_TOTAL-1
//   pixel_y     out  vertical position, 0 .. V_TOTAL-1
//   line_start  out  high for the advance that lands on pixel_x == 0
//   frame_start out  high for the advance that lands on (0,0)
//
// Every output is a register. Each one is decoded from the *next* counter
// value, so pixel_x/pixel_y and all flags change together on the same edge.
// H_TOTAL and V_TOTAL must fit in 10 bits. Every segment (porches and sync)
// must be at least one pixel/line wide, because the segment FSMs step on
// boundary matches.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic       pix_en,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       Hact,
    output logic       Vact,
    output logic       data_en,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Segment boundaries: the first coordinate of each segment.
    localparam logic [9:0] H_FP_START   = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_BP_START   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);

    localparam logic [9:0] V_FP_START   = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_BP_START   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);

    localparam logic SYNC_ON  = SYNC_POL;
    localparam logic SYNC_OFF = ~SYNC_POL;

    typedef enum logic [1:0] {
        SEG_ACTIVE,
        SEG_FRONT,
        SEG_SYNC,
        SEG_BACK
    } seg_t;

    seg_t       h_seg, h_seg_nxt;
    seg_t       v_seg, v_seg_nxt;
    logic [9:0] x_nxt, y_nxt;
    logic       line_wrap;

    logic       hs_nxt, vs_nxt;
    logic       hact_nxt, vact_nxt;
    logic       ls_nxt, fs_nxt;

    // Position that the counters take on the next advance.
    always_comb begin
        line_wrap = (pixel_x == H_LAST);
        x_nxt     = line_wrap ? 10'd0 : pixel_x + 10'd1;
        y_nxt     = pixel_y;
        if (line_wrap) begin
            y_nxt = (pixel_y == V_LAST) ? 10'd0 : pixel_y + 10'd1;
        end
    end

    // Horizontal segment FSM: moves when the next x hits a segment boundary.
    always_comb begin
        h_seg_nxt = h_seg;
        case (h_seg)
            SEG_ACTIVE: if (x_nxt == H_FP_START)   h_seg_nxt = SEG_FRONT;
            SEG_FRONT:  if (x_nxt == H_SYNC_START) h_seg_nxt = SEG_SYNC;
            SEG_SYNC:   if (x_nxt == H_BP_START)   h_seg_nxt = SEG_BACK;
            SEG_BACK:   if (x_nxt == 10'd0)        h_seg_nxt = SEG_ACTIVE;
            default:                               h_seg_nxt = SEG_BACK;
        endcase
    end

    // Vertical segment FSM: only evaluated on the advance that wraps the
    // line, so VGA_VS and Vact can only change together with pixel_x -> 0.
    always_comb begin
        v_seg_nxt = v_seg;
        if (line_wrap) begin
            case (v_seg)
                SEG_ACTIVE: if (y_nxt == V_FP_START)   v_seg_nxt = SEG_FRONT;
                SEG_FRONT:  if (y_nxt == V_SYNC_START) v_seg_nxt = SEG_SYNC;
                SEG_SYNC:   if (y_nxt == V_BP_START)   v_seg_nxt = SEG_BACK;
                SEG_BACK:   if (y_nxt == 10'd0)        v_seg_nxt = SEG_ACTIVE;
                default:                               v_seg_nxt = SEG_BACK;
            endcase
        end
    end

    // Output decode from the next segment/position so the registered flags
    // line up with the registered counters.
    always_comb begin
        hact_nxt = (h_seg_nxt == SEG_ACTIVE);
        vact_nxt = (v_seg_nxt == SEG_ACTIVE);
        hs_nxt   = (h_seg_nxt == SEG_SYNC) ? SYNC_ON : SYNC_OFF;
        vs_nxt   = (v_seg_nxt == SEG_SYNC) ? SYNC_ON : SYNC_OFF;
        ls_nxt   = (x_nxt == 10'd0);
        fs_nxt   = (x_nxt == 10'd0) && (y_nxt == 10'd0);
    end

    // Counters and segment state. Reset parks the raster on the very last
    // pixel of a frame so that the first advance lands on (0,0).
    always_ff @(posedge pixel_clk) begin
        if (!rst) begin
            pixel_x <= H_LAST;
            pixel_y <= V_LAST;
            h_seg   <= SEG_BACK;
            v_seg   <= SEG_BACK;
        end else if (pix_en) begin
            pixel_x <= x_nxt;
            pixel_y <= y_nxt;
            h_seg   <= h_seg_nxt;
            v_seg   <= v_seg_nxt;
        end
    end

    // Output registers. They hold between advances, so line_start and
    // frame_start stay high until the next strobe; consumers qualify them
    // with pix_en to see one event per advance.
    always_ff @(posedge pixel_clk) begin
        if (!rst) begin
            VGA_HS      <= SYNC_OFF;
            VGA_VS      <= SYNC_OFF;
            Hact        <= 1'b0;
            Vact        <= 1'b0;
            data_en     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            VGA_HS      <= hs_nxt;
            VGA_VS      <= vs_nxt;
            Hact        <= hact_nxt;
            Vact        <= vact_nxt;
            data_en     <= hact_nxt & vact_nxt;
            line_start  <= ls_nxt;
            frame_start <= fs_nxt;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Testbench for vga_timing_gen. Two instances share clock, reset and pix_en:
// dut_a uses the standard 640x480 timing with active-low sync, dut_b uses a
// tiny 15x11 raster with active-high sync so whole frames stay short.
module tb_vga_timing_gen;

    localparam int AHA = 640, AHF = 16, AHS = 96, AHB = 48;
    localparam int AVA = 480, AVF = 10, AVS = 2,  AVB = 33;
    localparam int AHT = 800, AVT = 525;
    localparam int BHA = 8,   BHF = 2,  BHS = 3,  BHB = 2;
    localparam int BVA = 6,   BVF = 1,  BVS = 2,  BVB = 2;
    localparam int BHT = 15,  BVT = 11;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs, vs, ha, va, de, ls, fs;
    } vec_t;

    typedef struct {
        vec_t a;
        vec_t b;
        int   a_win;
        int   b_win;
        bit   rst_cyc;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pix_en = 1'b0;
    always #5 clk = ~clk;

    logic       a_hs, a_vs, a_ha, a_va, a_de, a_ls, a_fs;
    logic [9:0] a_x, a_y;
    logic       b_hs, b_vs, b_ha, b_va, b_de, b_ls, b_fs;
    logic [9:0] b_x, b_y;

    vga_timing_gen #(
        .H_ACTIVE(AHA), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
        .V_ACTIVE(AVA), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB), .SYNC_POL(1'b0)
    ) dut_a (
        .pixel_clk(clk), .rst(rst), .pix_en(pix_en),
        .VGA_HS(a_hs), .VGA_VS(a_vs), .Hact(a_ha), .Vact(a_va), .data_en(a_de),
        .pixel_x(a_x), .pixel_y(a_y), .line_start(a_ls), .frame_start(a_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
        .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB), .SYNC_POL(1'b1)
    ) dut_b (
        .pixel_clk(clk), .rst(rst), .pix_en(pix_en),
        .VGA_HS(b_hs), .VGA_VS(b_vs), .Hact(b_ha), .Vact(b_va), .data_en(b_de),
        .pixel_x(b_x), .pixel_y(b_y), .line_start(b_ls), .frame_start(b_fs)
    );

    vec_t got_a, got_b;
    assign got_a = {a_x, a_y, a_hs, a_vs, a_ha, a_va, a_de, a_ls, a_fs};
    assign got_b = {b_x, b_y, b_hs, b_vs, b_ha, b_va, b_de, b_ls, b_fs};

    rec_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference raster positions and pulse flags, advanced by the stimulus.
    int ax, ay, bx, by;
    bit als, afs, bls, bfs;
    int cur_a_win = 0;
    int cur_b_win = 0;

    // Measurement accumulators, indexed by window number.
    int hs_cnt[5], ha_cnt[5], ls_cnt[5], vs_cnt[5], de_cnt[5];
    int rise_n[5], rise_t0[5], rise_t1[5];

    function automatic vec_t mk(int x, int y, bit hs, bit vs, bit ha, bit va,
                                bit de, bit ls, bit fs);
        vec_t v;
        v.x = 10'(x); v.y = 10'(y);
        v.hs = hs; v.vs = vs; v.ha = ha; v.va = va; v.de = de;
        v.ls = ls; v.fs = fs;
        return v;
    endfunction

    function automatic vec_t predict(int x, int y, int hact, int hfp, int hsync,
                                     int vact, int vfp, int vsync, bit pol,
                                     bit ls, bit fs);
        bit in_hs, in_vs;
        in_hs = (x >= hact + hfp) && (x < hact + hfp + hsync);
        in_vs = (y >= vact + vfp) && (y < vact + vfp + vsync);
        return mk(x, y, in_hs ? pol : ~pol, in_vs ? pol : ~pol,
                  x < hact, y < vact, (x < hact) && (y < vact), ls, fs);
    endfunction

    task automatic advance(inout int x, inout int y, input int ht, input int vt,
                           output bit ls, output bit fs);
        if (x == ht - 1) begin
            x = 0;
            y = (y == vt - 1) ? 0 : y + 1;
        end else begin
            x = x + 1;
        end
        ls = (x == 0);
        fs = (x == 0) && (y == 0);
    endtask

    task automatic step_x(input bit r, input bit en, input bit use_ha,
                          input vec_t ha, input bit use_hb, input vec_t hb);
        rec_t rc;
        @(negedge clk);
        rst    = r;
        pix_en = en;
        if (!r) begin
            ax = AHT - 1; ay = AVT - 1; als = 0; afs = 0;
            bx = BHT - 1; by = BVT - 1; bls = 0; bfs = 0;
        end else if (en) begin
            advance(ax, ay, AHT, AVT, als, afs);
            advance(bx, by, BHT, BVT, bls, bfs);
        end
        rc.a = use_ha ? ha : predict(ax, ay, AHA, AHF, AHS, AVA, AVF, AVS, 1'b0, als, afs);
        rc.b = use_hb ? hb : predict(bx, by, BHA, BHF, BHS, BVA, BVF, BVS, 1'b1, bls, bfs);
        rc.a_win   = cur_a_win;
        rc.b_win   = cur_b_win;
        rc.rst_cyc = !r;
        sb_q.push_back(rc);
    endtask

    task automatic step(input bit r, input bit en);
        step_x(r, en, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic check_vec(input string name, input int cyc, input vec_t got,
                             input vec_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got x=%0d y=%0d hs=%b vs=%b ha=%b va=%b de=%b ls=%b fs=%b required x=%0d y=%0d hs=%b vs=%b ha=%b va=%b de=%b ls=%b fs=%b",
                     name, cyc, got.x, got.y, got.hs, got.vs, got.ha, got.va, got.de, got.ls, got.fs,
                     exp.x, exp.y, exp.hs, exp.vs, exp.ha, exp.va, exp.de, exp.ls, exp.fs);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    // Monitor: pops one expectation per clock and compares away from the edge.
    initial begin : monitor
        rec_t rc;
        int   cyc;
        logic a_ls_prev, b_fs_prev, a_vs_prev, b_vs_prev;
        cyc = 0;
        a_ls_prev = 1'b0; b_fs_prev = 1'b0; a_vs_prev = 1'b0; b_vs_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (sb_q.size() > 0) begin
                rc = sb_q.pop_front();
                check_vec("dut_a", cyc, got_a, rc.a);
                check_vec("dut_b", cyc, got_b, rc.b);
                if (!rc.rst_cyc) begin
                    if (a_vs !== a_vs_prev) begin
                        tests++;
                        if (a_x !== 10'd0) begin
                            fails++;
                            $display("FAIL vs_a_edge got pixel_x=%0d required=0", a_x);
                        end
                    end
                    if (b_vs !== b_vs_prev) begin
                        tests++;
                        if (b_x !== 10'd0) begin
                            fails++;
                            $display("FAIL vs_b_edge got pixel_x=%0d required=0", b_x);
                        end
                    end
                end
                if (rc.a_win > 0) begin
                    if (a_hs === 1'b0) hs_cnt[rc.a_win]++;
                    if (a_ha === 1'b1) ha_cnt[rc.a_win]++;
                    if (a_ls === 1'b1) ls_cnt[rc.a_win]++;
                    if (a_ls === 1'b1 && a_ls_prev !== 1'b1) begin
                        if (rise_n[rc.a_win] == 0) rise_t0[rc.a_win] = cyc;
                        else if (rise_n[rc.a_win] == 1) rise_t1[rc.a_win] = cyc;
                        rise_n[rc.a_win]++;
                    end
                end
                if (rc.b_win > 0) begin
                    if (b_vs === 1'b1) vs_cnt[rc.b_win]++;
                    if (b_de === 1'b1) de_cnt[rc.b_win]++;
                    if (b_fs === 1'b1 && b_fs_prev !== 1'b1) begin
                        if (rise_n[rc.b_win] == 0) rise_t0[rc.b_win] = cyc;
                        else if (rise_n[rc.b_win] == 1) rise_t1[rc.b_win] = cyc;
                        rise_n[rc.b_win]++;
                    end
                end
            end
            a_ls_prev = a_ls; b_fs_prev = b_fs; a_vs_prev = a_vs; b_vs_prev = b_vs;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "testbench timeout");
    end

    initial begin : stimulus
        // Reset: pix_en is ignored while rst is low.
        step_x(1'b0, 1'b1, 1'b1, mk(799, 524, 1, 1, 0, 0, 0, 0, 0),
                           1'b1, mk(14, 10, 0, 0, 0, 0, 0, 0, 0));
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        // First two advances after release.
        step_x(1'b1, 1'b1, 1'b1, mk(0, 0, 1, 1, 1, 1, 1, 1, 1),
                           1'b1, mk(0, 0, 0, 0, 1, 1, 1, 1, 1));
        step_x(1'b1, 1'b1, 1'b1, mk(1, 0, 1, 1, 1, 1, 1, 0, 0),
                           1'b1, mk(1, 0, 0, 0, 1, 1, 1, 0, 0));
        // pix_en low: everything holds.
        step_x(1'b1, 1'b0, 1'b1, mk(1, 0, 1, 1, 1, 1, 1, 0, 0),
                           1'b1, mk(1, 0, 0, 0, 1, 1, 1, 0, 0));
        // Horizontal sync edges and line wrap on the standard timing.
        while (ax != 655) step(1'b1, 1'b1);
        step_x(1'b1, 1'b1, 1'b1, mk(656, 0, 0, 1, 0, 1, 0, 0, 0), 1'b0, '0);
        while (ax != 751) step(1'b1, 1'b1);
        step_x(1'b1, 1'b1, 1'b1, mk(752, 0, 1, 1, 0, 1, 0, 0, 0), 1'b0, '0);
        while (ax != 799) step(1'b1, 1'b1);
        step_x(1'b1, 1'b1, 1'b1, mk(0, 1, 1, 1, 1, 1, 1, 1, 0), 1'b0, '0);
        // Mid-frame reset for one edge, then release.
        while (ax != 300) step(1'b1, 1'b1);
        step_x(1'b0, 1'b1, 1'b1, mk(799, 524, 1, 1, 0, 0, 0, 0, 0),
                           1'b1, mk(14, 10, 0, 0, 0, 0, 0, 0, 0));
        step_x(1'b1, 1'b1, 1'b1, mk(0, 0, 1, 1, 1, 1, 1, 1, 1),
                           1'b1, mk(0, 0, 0, 0, 1, 1, 1, 1, 1));
        // Continuous advance: two lines of dut_a, two frames of dut_b.
        for (int i = 0; i < 1600; i++) begin
            cur_a_win = 1;
            cur_b_win = (i < 330) ? 3 : 0;
            step(1'b1, 1'b1);
        end
        cur_a_win = 0;
        cur_b_win = 0;
        // Vertical boundaries on the small raster.
        while (!(bx == 14 && by == 5)) step(1'b1, 1'b1);
        step_x(1'b1, 1'b1, 1'b0, '0, 1'b1, mk(0, 6, 0, 0, 1, 0, 0, 1, 0));
        while (!(bx == 14 && by == 6)) step(1'b1, 1'b1);
        step_x(1'b1, 1'b1, 1'b0, '0, 1'b1, mk(0, 7, 0, 1, 1, 0, 0, 1, 0));
        while (!(bx == 14 && by == 10)) step(1'b1, 1'b1);
        step_x(1'b1, 1'b1, 1'b0, '0, 1'b1, mk(0, 0, 0, 0, 1, 1, 1, 1, 1));
        // One-in-four strobe: four lines of dut_a, two frames of dut_b.
        for (int i = 0; i < 3200; i++) begin
            for (int k = 0; k < 4; k++) begin
                cur_a_win = 2;
                cur_b_win = ((i * 4 + k) < 1320) ? 4 : 0;
                step(1'b1, k == 0);
            end
        end
        cur_a_win = 0;
        cur_b_win = 0;
        repeat (3) @(negedge clk);
        chk_int("scoreboard_drained", sb_q.size(), 0);

        chk_int("w1_hs_low", hs_cnt[1], 192);
        chk_int("w1_hact", ha_cnt[1], 1280);
        chk_int("w1_line_start", ls_cnt[1], 2);
        chk_int("w1_line_rises", rise_n[1], 2);
        chk_int("w1_line_period", rise_t1[1] - rise_t0[1], 800);
        chk_int("w2_hs_low", hs_cnt[2], 1536);
        chk_int("w2_hact", ha_cnt[2], 10240);
        chk_int("w2_line_start", ls_cnt[2], 16);
        chk_int("w2_line_rises", rise_n[2], 4);
        chk_int("w2_line_period", rise_t1[2] - rise_t0[2], 3200);
        chk_int("w3_vs_active", vs_cnt[3], 60);
        chk_int("w3_data_en", de_cnt[3], 96);
        chk_int("w3_frame_rises", rise_n[3], 2);
        chk_int("w3_frame_period", rise_t1[3] - rise_t0[3], 165);
        chk_int("w4_vs_active", vs_cnt[4], 240);
        chk_int("w4_data_en", de_cnt[4], 384);
        chk_int("w4_frame_rises", rise_n[4], 2);
        chk_int("w4_frame_period", rise_t1[4] - rise_t0[4], 660);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 Parameter V_BP, default 33, vertical back porch in lines.
REQ-009 Parameter SYNC_POL, default 0, sync active level (0 = active-low).
REQ-010 pixel_clk  input  1  sole clock, all logic on rising edge.
REQ-011 rst  input  1  synchronous, active-low reset.
REQ-012 pix_en  input  1  pixel advance enable (tie 1 at 25 MHz; strobe 1-in-4 from 100 MHz).
REQ-013 VGA_HS  output  1  horizontal sync at SYNC_POL level during sync interval.
REQ-014 VGA_VS  output  1  vertical sync at SYNC_POL level during sync interval.
REQ-015 Hact  output  1  high while pixel_x < H_ACTIVE.
REQ-016 Vact  output  1  high while pixel_y < V_ACTIVE.
REQ-017 data_en  output  1  Hact AND Vact.
REQ-018 pixel_x  output  10  horizontal counter, 0..H_TOTAL-1.
REQ-019 pixel_y  output  10  vertical counter, 0..V_TOTAL-1.
REQ-020 line_start  output  1  one-advance pulse when pixel_x == 0.
REQ-021 frame_start  output  1  one-advance pulse when pixel_x == 0 and pixel_y == 0.

Function
REQ-022 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525); both SHALL fit in 10 bits.
REQ-023 Horizontal FSM states ACTIVE [0,H_ACTIVE), FRONT, SYNC [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) i.e. 656..751, BACK to H_TOTAL-1; vertical FSM identical in lines (sync 490..491).
REQ-024 On a rising edge with rst high and pix_en high, pixel_x SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and pixel_y SHALL increment.
REQ-025 pixel_y SHALL wrap from V_TOTAL-1 to 0 only on the same edge pixel_x wraps.
REQ-026 With pix_en low, all counters and outputs SHALL hold; line_start/frame_start SHALL hold too (one pulse per advance, decoders qualify with pix_en).
REQ-027 All outputs SHALL be registers updated on the same edge as the counters and SHALL describe the new counter value (zero latency between pixel_x/pixel_y and VGA_HS/VGA_VS/Hact/Vact/data_en).
REQ-028 VGA_HS SHALL depend only on pixel_x; VGA_VS SHALL change only at pixel_x == 0 transitions.
REQ-029 Hact SHALL rise exactly once per line, at pixel_x == 0, including during vertical blanking.
REQ-030 Frame period SHALL be exactly H_TOTAL*V_TOTAL advances (420000).

Reset
REQ-031 While rst low at an edge: pixel_x = H_TOTAL-1, pixel_y = V_TOTAL-1, Hact = Vact = data_en = 0, line_start = frame_start = 0, VGA_HS = VGA_VS = ~SYNC_POL; pix_en ignored.
REQ-032 First advance after rst rises SHALL give pixel_x = 0, pixel_y = 0, data_en = 1, line_start = 1, frame_start = 1.
REQ-033 Reset asserted mid-frame SHALL take effect on that edge with no partial-line completion.

Verification
REQ-034 Reset release, pix_en = 1: first edge -> (0,0), data_en = 1, frame_start = 1; next edge -> pixel_x = 1, frame_start = 0.
REQ-035 Run one line: VGA_HS low exactly for pixel_x 656..751 (96 clocks), Hact high for 640 clocks, line period 800 clocks.
REQ-036 Run one frame: VGA_VS low for pixel_y 490..491 (1600 clocks), asserting at pixel_x 0; data_en count = 307200; frame_start period = 420000 clocks.
REQ-037 pix_en = 1 one cycle in four: all periods exactly 4x REQ-035/036; outputs stable on idle cycles; line_start high one advance per line.
REQ-038 Boundary: at (799,524) next advance -> (0,0), frame_start = 1; at (799,479) next -> (0,480), Vact = 0, Hact = 1, data_en = 0.
REQ-039 rst low at (300,200) for one edge -> REQ-031 values; release -> (0,0) frame_start = 1; SYNC_POL = 1 build inverts VGA_HS/VGA_VS only.
